// File: rtl/kmer_hash_sched.sv
// rtl/kmer_hash_sched.sv - streaming base-4 rolling k-mer hash scheduler
// Optional KMER_CANONICAL_EN: emit min(forward, reverse-complement) hash.
module kmer_hash_sched #(
  parameter int K     = 4,
  parameter int POS_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       char_in,
  input  logic             char_valid,
  output logic             char_ready,
  input  logic             seq_start,
  output logic [31:0]      hash_out,
  output logic [POS_W-1:0] pos_out,
  output logic             hash_valid,
  input  logic             hash_ready
);

  localparam int CW  = $clog2(K + 1);
  localparam int OSH = 2 * (K - 1);
  localparam logic [31:0]   HMASK = (K >= 16) ? 32'hFFFF_FFFF : ((32'd1 << (2 * K)) - 32'd1);
  localparam logic [CW-1:0] KC    = CW'(K);

  typedef enum logic {FILL, ROLL} phase_t;

  logic [CW-1:0]      fill_cnt, fill_b, fill_nx;
  logic [31:0]        hash, hash_b, hash_nx, hash_ld;
  logic [K-1:0][1:0]  window, window_b, window_nx;
  logic [POS_W-1:0]   pos, pos_b, pos_nx;
  logic [31:0]        hash_out_r;
  logic [POS_W-1:0]   pos_out_r;
  logic               hash_valid_r;
  logic               accept, load, code_ok;
  logic [1:0]         code, out_code;
  phase_t             phase;
`ifdef KMER_CANONICAL_EN
  logic [31:0]        rc, rc_b, rc_nx;
`endif

  assign char_ready = !hash_valid_r || hash_ready;
  assign accept     = char_valid && char_ready;
  assign hash_out   = hash_out_r;
  assign pos_out    = pos_out_r;
  assign hash_valid = hash_valid_r;

  always_comb begin
    code    = 2'd0;
    code_ok = 1'b1;
    case (char_in)
      8'h41, 8'h61: code = 2'd0;
      8'h43, 8'h63: code = 2'd1;
      8'h47, 8'h67: code = 2'd2;
      8'h54, 8'h74: code = 2'd3;
      default:      code_ok = 1'b0;
    endcase
  end

  // seq_start clears first so a simultaneous accept lands at position 0
  always_comb begin
    fill_b   = seq_start ? '0 : fill_cnt;
    hash_b   = seq_start ? '0 : hash;
    window_b = seq_start ? '0 : window;
    pos_b    = seq_start ? '0 : pos;
    phase    = (fill_b == KC) ? ROLL : FILL;
    out_code = window_b[K-1];
    fill_nx  = fill_b;
    hash_nx  = hash_b;
    window_nx = window_b;
    pos_nx   = pos_b;
    load     = 1'b0;
`ifdef KMER_CANONICAL_EN
    rc_b  = seq_start ? '0 : rc;
    rc_nx = rc_b;
`endif
    if (accept) begin
      pos_nx = pos_b + POS_W'(1);
      if (code_ok) begin
        for (int i = K - 1; i > 0; i--) window_nx[i] = window_b[i-1];
        window_nx[0] = code;
`ifdef KMER_CANONICAL_EN
        rc_nx = (rc_b >> 2) | ({30'd0, 2'd3 - code} << OSH);
`endif
        case (phase)
          FILL: begin
            hash_nx = ((hash_b << 2) | {30'd0, code}) & HMASK;
            fill_nx = fill_b + CW'(1);
            load    = (fill_b == KC - CW'(1));
          end
          ROLL: begin
            hash_nx = (((hash_b - ({30'd0, out_code} << OSH)) << 2) | {30'd0, code}) & HMASK;
            load    = 1'b1;
          end
          default: ;
        endcase
      end else begin
        fill_nx = '0;
        hash_nx = '0;
`ifdef KMER_CANONICAL_EN
        rc_nx = '0;
`endif
      end
    end
`ifdef KMER_CANONICAL_EN
    hash_ld = (rc_nx < hash_nx) ? rc_nx : hash_nx;
`else
    hash_ld = hash_nx;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt     <= '0;
      hash         <= '0;
      window       <= '0;
      pos          <= '0;
      hash_out_r   <= '0;
      pos_out_r    <= '0;
      hash_valid_r <= 1'b0;
`ifdef KMER_CANONICAL_EN
      rc           <= '0;
`endif
    end else begin
      fill_cnt <= fill_nx;
      hash     <= hash_nx;
      window   <= window_nx;
      pos      <= pos_nx;
`ifdef KMER_CANONICAL_EN
      rc       <= rc_nx;
`endif
      // a load only happens on accept, which implies the old hash was taken
      if (load) begin
        hash_valid_r <= 1'b1;
        hash_out_r   <= hash_ld;
        pos_out_r    <= pos_b;
      end else if (hash_ready) begin
        hash_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_kmer_hash_sched.sv
// tb/tb_kmer_hash_sched.sv - self-checking bench for kmer_hash_sched
module tb_kmer_hash_sched;
  localparam int K = 4;
  localparam int POS_W = 16;
`ifdef KMER_CANONICAL_EN
  localparam int EXP_CGAT = 32'h36;
  localparam int EXP_GGGG = 32'h55;
`else
  localparam int EXP_CGAT = 32'h63;
  localparam int EXP_GGGG = 32'hAA;
`endif

  logic             clk;
  logic             rst;
  logic [7:0]       char_in;
  logic             char_valid;
  logic             char_ready;
  logic             seq_start;
  logic [31:0]      hash_out;
  logic [POS_W-1:0] pos_out;
  logic             hash_valid;
  logic             hash_ready;

  kmer_hash_sched #(.K(K), .POS_W(POS_W)) dut (
    .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .seq_start(seq_start), .hash_out(hash_out),
    .pos_out(pos_out), .hash_valid(hash_valid), .hash_ready(hash_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests, fails;
  int exp_h[$], exp_p[$];
  int fired_h[$], fired_p[$];
  int run[$];
  int mpos;
  logic        s_ready, s_hv;
  logic [31:0] s_hout;

  function automatic int code_of(input logic [7:0] c);
    case (c)
      "A", "a": return 0;
      "C", "c": return 1;
      "G", "g": return 2;
      "T", "t": return 3;
      default:  return -1;
    endcase
  endfunction

  // k-mer value straight from the last K bases of the current run
  function automatic int model_hash();
    int f, r;
    f = 0;
    r = 0;
    for (int j = 0; j < K; j++) begin
      f = f * 4 + run[j];
      r = r + ((3 - run[j]) << (2 * j));
    end
`ifdef KMER_CANONICAL_EN
    return (r < f) ? r : f;
`else
    return f;
`endif
  endfunction

  task automatic step(input logic v, input logic [7:0] ch, input logic hr,
                      input logic ss, input logic r);
    int c;
    char_valid = v; char_in = ch; hash_ready = hr; seq_start = ss; rst = r;
    @(negedge clk);
    s_ready = char_ready; s_hout = hash_out; s_hv = hash_valid;
    if (r) begin
      exp_h.delete(); exp_p.delete(); run.delete(); mpos = 0;
    end else begin
      tests++;
      if (hash_valid !== (exp_h.size() != 0)) begin
        fails++;
        $display("FAIL hash_valid: got %0b expected %0b", hash_valid, exp_h.size() != 0);
      end
      tests++;
      if (char_ready !== (exp_h.size() == 0 || hr)) begin
        fails++;
        $display("FAIL char_ready: got %0b expected %0b", char_ready, exp_h.size() == 0 || hr);
      end
      if (hash_valid && hr && exp_h.size() != 0) begin
        tests++;
        if (hash_out !== 32'(exp_h[0]) || pos_out !== POS_W'(exp_p[0])) begin
          fails++;
          $display("FAIL output: got hash %0h pos %0d expected hash %0h pos %0d",
                   hash_out, pos_out, exp_h[0], exp_p[0]);
        end
        fired_h.push_back(int'(hash_out));
        fired_p.push_back(int'(pos_out));
        void'(exp_h.pop_front());
        void'(exp_p.pop_front());
      end
      if (ss) begin
        run.delete();
        mpos = 0;
      end
      if (v && char_ready) begin
        c = code_of(ch);
        if (c < 0) run.delete();
        else begin
          run.push_back(c);
          if (run.size() > K) void'(run.pop_front());
          if (run.size() == K) begin
            exp_h.push_back(model_hash());
            exp_p.push_back(mpos);
          end
        end
        mpos = (mpos + 1) % (1 << POS_W);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, "A", 1'b0, 1'b0, 1'b1);
    step(1'b0, "A", 1'b0, 1'b0, 1'b1);
    fired_h.delete();
    fired_p.delete();
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i], 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, "A", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic check_fired(input string name, input int idx, input int h, input int p);
    tests++;
    if (fired_h.size() <= idx) begin
      fails++;
      $display("FAIL %s: got %0d outputs expected index %0d present", name, fired_h.size(), idx);
    end else if (fired_h[idx] != h || fired_p[idx] != p) begin
      fails++;
      $display("FAIL %s: got hash %0h pos %0d expected hash %0h pos %0d",
               name, fired_h[idx], fired_p[idx], h, p);
    end
  endtask

  task automatic check_count(input string name, input int n);
    tests++;
    if (fired_h.size() != n) begin
      fails++;
      $display("FAIL %s: got %0d outputs expected %0d", name, fired_h.size(), n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    step(1'b0, "A", 1'b0, 1'b0, 1'b0);
    tests++;
    if (s_hv !== 1'b0 || s_ready !== 1'b1 || s_hout !== 32'd0 || pos_out !== '0) begin
      fails++;
      $display("FAIL reset: got hv %0b rdy %0b hash %0h pos %0d expected 0 1 0 0",
               s_hv, s_ready, s_hout, pos_out);
    end
  endtask

  task automatic test_basic();
    do_reset();
    step(1'b1, "A", 1'b1, 1'b1, 1'b0);
    send("TCG");
    step(1'b1, "A", 1'b1, 1'b0, 1'b0);
    tests++;
    if (s_hv !== 1'b1 || s_hout !== 32'h36) begin
      fails++;
      $display("FAIL latency: got hv %0b hash %0h expected 1 36", s_hv, s_hout);
    end
    idle(3);
    check_fired("atcg", 0, 32'h36, 3);
    check_fired("atcga", 1, 32'hD8, 4);
    check_count("atcga_count", 2);
  endtask

  task automatic test_invalid();
    do_reset();
    send("ACNGTCA");
    idle(3);
    check_fired("invalid_n", 0, 32'hB4, 6);
    check_count("invalid_count", 1);
  endtask

  task automatic test_backpressure();
    do_reset();
    send("ATCG");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, "A", 1'b0, 1'b0, 1'b0);
      tests++;
      if (s_ready !== 1'b0 || s_hout !== 32'h36 || s_hv !== 1'b1) begin
        fails++;
        $display("FAIL backpressure: got rdy %0b hv %0b hash %0h expected 0 1 36",
                 s_ready, s_hv, s_hout);
      end
    end
    step(1'b1, "A", 1'b1, 1'b0, 1'b0);
    idle(3);
    check_fired("bp_first", 0, 32'h36, 3);
    check_fired("bp_second", 1, 32'hD8, 4);
    check_count("bp_count", 2);
  endtask

  task automatic test_reset_mid();
    do_reset();
    send("AT");
    step(1'b0, "A", 1'b1, 1'b0, 1'b1);
    send("CGAT");
    idle(3);
    check_fired("reset_mid", 0, EXP_CGAT, 3);
    check_count("reset_mid_count", 1);
  endtask

  task automatic test_seq_start();
    do_reset();
    send("ATCG");
    step(1'b1, "G", 1'b1, 1'b1, 1'b0);
    send("GGG");
    idle(3);
    check_fired("seq_first", 0, 32'h36, 3);
    check_fired("seq_restart", 1, EXP_GGGG, 3);
    check_count("seq_count", 2);
  endtask

`ifdef KMER_CANONICAL_EN
  task automatic test_canonical();
    do_reset();
    send("TTTT"); idle(2);
    check_fired("canon_tttt", 0, 32'h00, 3);
    do_reset();
    send("ATCG"); idle(2);
    check_fired("canon_atcg", 0, 32'h36, 3);
    do_reset();
    send("GTCA"); idle(2);
    check_fired("canon_gtca", 0, 32'hB4, 3);
  endtask
`endif

  task automatic test_random();
    string alpha;
    alpha = "ACGTACGTacgtNx";
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 8, alpha[$urandom_range(0, alpha.len() - 1)],
           $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, 1'b0);
    end
    for (int i = 0; i < 10 && exp_h.size() != 0; i++) idle(1);
    tests++;
    if (exp_h.size() != 0) begin
      fails++;
      $display("FAIL random_drain: got %0d pending expected 0", exp_h.size());
    end
    tests++;
    if (fired_h.size() < 20) begin
      fails++;
      $display("FAIL random_activity: got %0d outputs expected at least 20", fired_h.size());
    end
  endtask

  initial begin
    tests = 0; fails = 0; mpos = 0;
    rst = 1'b1; char_in = 8'h0; char_valid = 1'b0; seq_start = 1'b0; hash_ready = 1'b0;
    test_reset();
    test_basic();
    test_invalid();
    test_backpressure();
    test_reset_mid();
    test_seq_start();
`ifdef KMER_CANONICAL_EN
    test_canonical();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
